sprite_line_scheduler: RTL and testbench

SPRITE_LINE_SCHEDULER -- requirements
Module: sprite_line_scheduler

---
 rtl/sprite_line_scheduler_if.sv | 36 +++
 rtl/sprite_line_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_line_scheduler_if
// Description : Fetch request/acknowledge bundle between the sprite line
//               scheduler (master) and the sprite pattern fetcher (slave).
//               fetch_req  - request valid
//               fetch_id   - sprite index to fetch
//               fetch_row  - row within the sprite for the prepared line
//               fetch_slot - destination line-buffer slot
//               fetch_ack  - fetcher accepted the current request
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_line_scheduler_if;
  logic       fetch_req;
  logic [2:0] fetch_id;
  logic [5:0] fetch_row;
  logic [1:0] fetch_slot;
  logic       fetch_ack;

  modport master (
    output fetch_req,
    output fetch_id,
    output fetch_row,
    output fetch_slot,
    input  fetch_ack
  );

  modport slave (
    input  fetch_req,
    input  fetch_id,
    input  fetch_row,
    input  fetch_slot,
    output fetch_ack
  );
endinterface
`default_nettype wire

// File: rtl/sprite_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sprite_line_scheduler
// Description : Per-scanline sprite evaluator. On each h_sync rising edge the
//               line counter advances and the sprite table is scanned one
//               entry per cycle; every sprite covering the new line is issued
//               as a fetch request (up to MAX_SLOTS per line). A v_sync edge
//               clears the line counter and abandons any work in progress.
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous reset, active low
//               h_sync     - horizontal sync (rising edge starts a line)
//               v_sync     - vertical sync (rising edge restarts the frame)
//               spr_en     - per-sprite enable
//               spr_y      - packed sprite top lines, 10 bits per entry
//               spr_h      - packed sprite heights, 6 bits per entry
//               fetch      - fetch request/ack bundle (master side)
//               V_pos      - current line number since last v_sync
//               slot_valid - slots filled for the prepared line
//               line_ready - one-cycle pulse when a line is fully scheduled
//               overflow   - sticky per line: too many hits or h_sync overrun
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_line_scheduler #(
  parameter int NUM_SPR   = 8,
  parameter int MAX_SLOTS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   h_sync,
  input  logic                   v_sync,
  input  logic [NUM_SPR-1:0]     spr_en,
  input  logic [10*NUM_SPR-1:0]  spr_y,
  input  logic [6*NUM_SPR-1:0]   spr_h,
  sprite_line_scheduler_if.master fetch,
  output logic [9:0]             V_pos,
  output logic [MAX_SLOTS-1:0]   slot_valid,
  output logic                   line_ready,
  output logic                   overflow
);

  localparam int IDX_W  = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int SLOT_W = $clog2(MAX_SLOTS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic                 hs_q;
  logic                 vs_q;
  logic [9:0]           V_pos_q;
  logic [IDX_W-1:0]     idx_q;
  logic [SLOT_W-1:0]    slot_cnt_q;
  logic [MAX_SLOTS-1:0] slot_valid_q;
  logic                 fetch_req_q;
  logic [2:0]           fetch_id_q;
  logic [5:0]           fetch_row_q;
  logic [1:0]           fetch_slot_q;
  logic                 line_ready_q;
  logic                 overflow_q;

  // Unpack the flat sprite table so the scan index can select an entry.
  logic [9:0] y_arr [NUM_SPR];
  logic [5:0] h_arr [NUM_SPR];

  genvar g;
  generate
    for (g = 0; g < NUM_SPR; g++) begin : g_unpack
      assign y_arr[g] = spr_y[10*g +: 10];
      assign h_arr[g] = spr_h[6*g +: 6];
    end
  endgenerate

  logic        hs_edge;
  logic        vs_edge;
  logic        cur_en;
  logic [9:0]  cur_y;
  logic [5:0]  cur_h;
  logic [10:0] diff;
  logic        hit;
  logic        last_idx;
  logic        slots_full;

  assign hs_edge = h_sync & ~hs_q;
  assign vs_edge = v_sync & ~vs_q;

  assign cur_en = spr_en[idx_q];
  assign cur_y  = y_arr[idx_q];
  assign cur_h  = h_arr[idx_q];

  // 11-bit compare: a sprite near line 1023 must not wrap onto early lines.
  assign diff       = {1'b0, V_pos_q} - {1'b0, cur_y};
  assign hit        = cur_en && (V_pos_q >= cur_y) && (diff < {5'b0, cur_h});
  assign last_idx   = (idx_q == IDX_W'(NUM_SPR - 1));
  assign slots_full = (slot_cnt_q == SLOT_W'(MAX_SLOTS));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      V_pos_q      <= '0;
      idx_q        <= '0;
      slot_cnt_q   <= '0;
      slot_valid_q <= '0;
      fetch_req_q  <= 1'b0;
      fetch_id_q   <= '0;
      fetch_row_q  <= '0;
      fetch_slot_q <= '0;
      line_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      hs_q         <= h_sync;
      vs_q         <= v_sync;
      line_ready_q <= 1'b0;

      if (vs_edge) begin
        // Frame restart wins over a coincident h_sync edge.
        V_pos_q      <= '0;
        state_q      <= IDLE;
        fetch_req_q  <= 1'b0;
        slot_valid_q <= '0;
      end else if (hs_edge) begin
        // New line; an unfinished previous line is reported as overrun.
        V_pos_q      <= V_pos_q + 10'd1;
        state_q      <= SCAN;
        idx_q        <= '0;
        slot_cnt_q   <= '0;
        slot_valid_q <= '0;
        fetch_req_q  <= 1'b0;
        overflow_q   <= (state_q != IDLE);
      end else begin
        case (state_q)
          IDLE: ;
          SCAN: begin
            if (hit) begin
              if (slots_full) begin
                overflow_q <= 1'b1;
                state_q    <= DONE;
              end else begin
                fetch_req_q  <= 1'b1;
                fetch_id_q   <= 3'(idx_q);
                fetch_row_q  <= diff[5:0];
                fetch_slot_q <= 2'(slot_cnt_q);
                state_q      <= FETCH;
              end
            end else if (last_idx) begin
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
          FETCH: begin
            if (fetch.fetch_ack) begin
              fetch_req_q  <= 1'b0;
              slot_valid_q <= slot_valid_q | (MAX_SLOTS'(1) << slot_cnt_q);
              slot_cnt_q   <= slot_cnt_q + SLOT_W'(1);
              if (last_idx) begin
                state_q <= DONE;
              end else begin
                idx_q   <= idx_q + IDX_W'(1);
                state_q <= SCAN;
              end
            end
          end
          DONE: begin
            line_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign V_pos            = V_pos_q;
  assign slot_valid       = slot_valid_q;
  assign line_ready       = line_ready_q;
  assign overflow         = overflow_q;
  assign fetch.fetch_req  = fetch_req_q;
  assign fetch.fetch_id   = fetch_id_q;
  assign fetch.fetch_row  = fetch_row_q;
  assign fetch.fetch_slot = fetch_slot_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_line_scheduler
// Description : Self-checking bench for sprite_line_scheduler. Expected fetch
//               lists, overflow and slot masks come from a plain arithmetic
//               model of which sprites cover a given line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_line_scheduler;
  localparam int NS = 8;
  localparam int MS = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            h_sync = 1'b0;
  logic            v_sync = 1'b0;
  logic [NS-1:0]   spr_en = '0;
  logic [10*NS-1:0] spr_y = '0;
  logic [6*NS-1:0] spr_h = '0;
  logic [9:0]      V_pos;
  logic [MS-1:0]   slot_valid;
  logic            line_ready;
  logic            overflow;

  sprite_line_scheduler_if fif();

  sprite_line_scheduler #(.NUM_SPR(NS), .MAX_SLOTS(MS)) dut (
    .clk        (clk),
    .rst        (rst),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .spr_en     (spr_en),
    .spr_y      (spr_y),
    .spr_h      (spr_h),
    .fetch      (fif),
    .V_pos      (V_pos),
    .slot_valid (slot_valid),
    .line_ready (line_ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sprite table and reference results.
  int t_en [NS];
  int t_y  [NS];
  int t_h  [NS];
  int exp_id[$];
  int exp_row[$];
  int n_hits;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_table();
    for (int i = 0; i < NS; i++) begin
      t_en[i] = 0; t_y[i] = 0; t_h[i] = 0;
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < NS; i++) begin
      spr_en[i]         = (t_en[i] != 0);
      spr_y[10*i +: 10] = 10'(t_y[i]);
      spr_h[6*i +: 6]   = 6'(t_h[i]);
    end
  endtask

  // A sprite covers line L when L lies in [y, y+h); first MS of them are fetched.
  task automatic build_model(input int L);
    exp_id.delete();
    exp_row.delete();
    n_hits = 0;
    for (int i = 0; i < NS; i++) begin
      if (t_en[i] != 0 && L >= t_y[i] && (L - t_y[i]) < t_h[i]) begin
        n_hits++;
        if (exp_id.size() < MS) begin
          exp_id.push_back(i);
          exp_row.push_back(L - t_y[i]);
        end
      end
    end
  endtask

  // Leaves V_pos at L-1 with the scheduler idle and every sprite disabled.
  task automatic goto_line(input int L);
    spr_en = '0;
    v_sync = 1'b1; tick(); v_sync = 1'b0; tick();
    for (int k = 0; k < L - 1; k++) begin
      h_sync = 1'b1; tick(); h_sync = 1'b0; tick();
    end
    repeat (15) tick();
  endtask

  task automatic hpulse();
    h_sync = 1'b1; tick(); h_sync = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int w;
    w = 0;
    while (!fif.fetch_req && w < 40) begin
      tick(); w++;
    end
    chk(tag, fif.fetch_req, 1);
  endtask

  task automatic wait_ready(output int extra);
    int w;
    w = 0;
    extra = 0;
    while (!line_ready && w < 60) begin
      if (fif.fetch_req) extra++;
      tick(); w++;
    end
    chk("line_ready", line_ready, 1);
  endtask

  task automatic ack();
    fif.fetch_ack = 1'b1; tick(); fif.fetch_ack = 1'b0;
  endtask

  task automatic run_line(input int L, input int stall_min, input int stall_max);
    int d;
    int extra;
    bit stable;
    logic [2:0] sid;
    logic [5:0] srow;
    logic [1:0] sslot;
    goto_line(L);
    load_table();
    build_model(L);
    hpulse();
    chk("vpos", V_pos, L);
    for (int k = 0; k < exp_id.size(); k++) begin
      wait_req("req_seen");
      chk("id", fif.fetch_id, exp_id[k]);
      chk("row", fif.fetch_row, exp_row[k]);
      chk("slot", fif.fetch_slot, k);
      sid = fif.fetch_id; srow = fif.fetch_row; sslot = fif.fetch_slot;
      d = $urandom_range(stall_max, stall_min);
      stable = 1'b1;
      repeat (d) begin
        tick();
        if (!fif.fetch_req || fif.fetch_id != sid || fif.fetch_row != srow ||
            fif.fetch_slot != sslot) stable = 1'b0;
      end
      chk("stall_stable", stable, 1);
      ack();
      chk("req_drop", fif.fetch_req, 0);
    end
    wait_ready(extra);
    chk("extra_req", extra, 0);
    chk("slot_valid", slot_valid, (1 << exp_id.size()) - 1);
    chk("overflow", overflow, (n_hits > MS));
    tick();
    chk("lr_pulse", line_ready, 0);
  endtask

  initial begin
    int extra;
    int quiet;
    fif.fetch_ack = 1'b0;
    clear_table();

    // Reset values.
    repeat (3) tick();
    chk("rst_vpos", V_pos, 0);
    chk("rst_req", fif.fetch_req, 0);
    chk("rst_sv", slot_valid, 0);
    chk("rst_lr", line_ready, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b1;
    tick();

    // Single sprite, basic scan.
    clear_table();
    t_en[0] = 1; t_y[0] = 10; t_h[0] = 4;
    run_line(10, 0, 2);

    // Six coincident sprites overflow the four slots.
    clear_table();
    for (int i = 0; i < 6; i++) begin
      t_en[i] = 1; t_y[i] = 5; t_h[i] = 8;
    end
    run_line(7, 0, 1);

    // Vertical boundaries, zero height, and no wrap near line 1023.
    clear_table();
    t_en[0] = 1; t_y[0] = 20; t_h[0] = 3;
    t_en[1] = 1; t_y[1] = 20; t_h[1] = 0;
    for (int L = 19; L <= 23; L++) run_line(L, 0, 0);
    clear_table();
    t_en[2] = 1; t_y[2] = 1020; t_h[2] = 8;
    run_line(3, 0, 0);

    // Long handshake stall.
    clear_table();
    t_en[1] = 1; t_y[1] = 30; t_h[1] = 5;
    t_en[4] = 1; t_y[4] = 28; t_h[4] = 6;
    run_line(32, 10, 10);

    // h_sync overrun while a request is pending.
    clear_table();
    t_en[0] = 1; t_y[0] = 10; t_h[0] = 4;
    goto_line(10);
    load_table();
    hpulse();
    wait_req("ovr_req");
    hpulse();
    chk("ovr_req_drop", fif.fetch_req, 0);
    chk("ovr_flag", overflow, 1);
    chk("ovr_vpos", V_pos, 11);
    wait_req("ovr_req2");
    chk("ovr_row", fif.fetch_row, 1);
    ack();
    wait_ready(extra);
    chk("ovr_sticky", overflow, 1);
    chk("ovr_sv", slot_valid, 1);

    // Coincident v_sync and h_sync during FETCH.
    goto_line(10);
    load_table();
    hpulse();
    wait_req("sp_req");
    v_sync = 1'b1; h_sync = 1'b1; tick(); v_sync = 1'b0; h_sync = 1'b0;
    chk("sp_vpos", V_pos, 0);
    chk("sp_req", fif.fetch_req, 0);
    chk("sp_sv", slot_valid, 0);
    quiet = 0;
    repeat (15) begin
      tick();
      if (line_ready || fif.fetch_req) quiet++;
    end
    chk("sp_quiet", quiet, 0);

    // Reset during FETCH.
    clear_table();
    t_en[3] = 1; t_y[3] = 10; t_h[3] = 4;
    goto_line(11);
    load_table();
    hpulse();
    wait_req("rf_req");
    chk("rf_id", fif.fetch_id, 3);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("rf_vpos", V_pos, 0);
    chk("rf_req", fif.fetch_req, 0);
    chk("rf_id0", fif.fetch_id, 0);
    chk("rf_row0", fif.fetch_row, 0);
    chk("rf_slot0", fif.fetch_slot, 0);
    chk("rf_sv", slot_valid, 0);
    chk("rf_lr", line_ready, 0);
    chk("rf_ovf", overflow, 0);
    ack();
    quiet = 0;
    repeat (5) begin
      tick();
      if (fif.fetch_req || slot_valid != 0 || line_ready) quiet++;
    end
    chk("rf_ack_ignored", quiet, 0);

    // Randomized tables and lines.
    for (int it = 0; it < 15; it++) begin
      int L;
      L = $urandom_range(60, 1);
      for (int i = 0; i < NS; i++) begin
        t_en[i] = $urandom_range(1, 0);
        t_y[i]  = $urandom_range(63, 0);
        t_h[i]  = $urandom_range(15, 0);
      end
      run_line(L, 0, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
